sub_seq_ctrl: RTL and testbench

SUB_SEQ_CTRL -- requirements
Module: sub_seq_ctrl

---
 rtl/sub_seq_pkg.sv | 13 +
 rtl/nib_sub.sv | 19 +
 rtl/sub_seq_ctrl.sv | 157 +++++++++++++++
 tb/tb_sub_seq_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/sub_seq_pkg.sv
// Shared types and constants for the nibble-serial subtract controller.
// FSM encoding and the datapath slice width live here.
package sub_seq_pkg;

    localparam int unsigned NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nib_sub.sv
// 4-bit subtract-with-borrow slice: d = a - b - bin, bout set when the result underflows.
module nib_sub
    import sub_seq_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             bin,
    output logic [NIB_W-1:0] d,
    output logic             bout
);

    logic [NIB_W:0] w_full;

    // One extra bit catches the underflow as the borrow-out
    assign w_full = {1'b0, a} - {1'b0, b} - (NIB_W+1)'(bin);
    assign d      = w_full[NIB_W-1:0];
    assign bout   = w_full[NIB_W];

endmodule

// File: rtl/sub_seq_ctrl.sv
// Two-requester, round-robin, nibble-serial unsigned subtractor with a held result.
// Optional SUB_SEQ_SAT_EN: floor the difference at zero when the final borrow is set.
module sub_seq_ctrl
    import sub_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic             req1_valid,
    output logic             req0_ready,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_diff,
    output logic             res_borrow,
    output logic             res_id,
    output logic             busy
);

    localparam int unsigned NIB_CNT  = WIDTH / NIB_W;
    localparam int unsigned IDX_W    = $clog2(NIB_CNT);
    localparam int unsigned LAST_IDX = NIB_CNT - 1;

    state_t             r_state;
    state_t             w_next;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_diff;
    logic               r_borrow;
    logic               r_id;
    logic               r_prio;
    logic [IDX_W-1:0]   r_idx;

    logic               w_gnt;
    logic               w_gnt_vld;
    logic               w_accept;
    logic               w_last;
    logic [NIB_W-1:0]   w_nib_d;
    logic               w_bout;

    // Round-robin grant: r_prio names the requester that wins a tie
    assign w_gnt_vld = req0_valid | req1_valid;
    assign w_gnt     = r_prio ? req1_valid : ~req0_valid;
    assign w_last    = (r_idx == IDX_W'(LAST_IDX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next = RUN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Ready is held low during reset even though the state already reads IDLE
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        res_valid  = 1'b0;
        busy       = 1'b0;
        w_accept   = 1'b0;
        if (rst_n && (r_state == IDLE) && w_gnt_vld) begin
            req0_ready = ~w_gnt;
            req1_ready = w_gnt;
            w_accept   = 1'b1;
        end
        if (r_state == DONE) begin
            res_valid = 1'b1;
        end
        if (r_state != IDLE) begin
            busy = 1'b1;
        end
    end

    nib_sub u_nib_sub (
        .a    (r_a[NIB_W-1:0]),
        .b    (r_b[NIB_W-1:0]),
        .bin  (r_borrow),
        .d    (w_nib_d),
        .bout (w_bout)
    );

    // Operands shift right one nibble per RUN cycle; the difference fills in from the top
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_id     <= 1'b0;
            r_prio   <= 1'b0;
            r_idx    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a      <= w_gnt ? req1_a : req0_a;
                        r_b      <= w_gnt ? req1_b : req0_b;
                        r_id     <= w_gnt;
                        r_prio   <= ~w_gnt;
                        r_borrow <= 1'b0;
                        r_idx    <= '0;
                    end
                end
                RUN: begin
                    r_a      <= r_a >> NIB_W;
                    r_b      <= r_b >> NIB_W;
                    r_borrow <= w_bout;
                    r_idx    <= r_idx + IDX_W'(1);
`ifdef SUB_SEQ_SAT_EN
                    if (w_last && w_bout) begin
                        r_diff <= '0;
                    end else begin
                        r_diff <= {w_nib_d, r_diff[WIDTH-1:NIB_W]};
                    end
`else
                    r_diff   <= {w_nib_d, r_diff[WIDTH-1:NIB_W]};
`endif
                end
                default: ;
            endcase
        end
    end

    assign res_diff   = r_diff;
    assign res_borrow = r_borrow;
    assign res_id     = r_id;

endmodule

// File: tb/tb_sub_seq_ctrl.sv
// Scoreboard bench for sub_seq_ctrl: expectations pushed on accept, popped on result handshake.
module tb_sub_seq_ctrl;

    localparam int unsigned WIDTH = 16;

    typedef struct {
        logic [WIDTH-1:0] diff;
        logic             borrow;
        logic             id;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req0_valid, req1_valid;
    logic             req0_ready, req1_ready;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic             res_valid, res_ready;
    logic [WIDTH-1:0] res_diff;
    logic             res_borrow, res_id, busy;

    exp_t sb[$];
    logic acc_ids[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   acc_cyc  = 0;
    logic prev_valid = 1'b0;

    sub_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req1_valid (req1_valid),
        .req0_ready (req0_ready),
        .req1_ready (req1_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_diff   (res_diff),
        .res_borrow (res_borrow),
        .res_id     (res_id),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic id);
        exp_t e;
        e.diff   = a - b;
        e.borrow = (a < b);
`ifdef SUB_SEQ_SAT_EN
        if (e.borrow) e.diff = '0;
`endif
        e.id = id;
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Monitor: push on accept, check latency on rise, pop and compare on handshake
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else begin
            check("one_ready", 32'(req0_ready & req1_ready), 32'd0);
            if (req0_valid && req0_ready) begin
                sb.push_back(model(req0_a, req0_b, 1'b0));
                acc_ids.push_back(1'b0);
                acc_cyc = cyc;
            end
            if (req1_valid && req1_ready) begin
                sb.push_back(model(req1_a, req1_b, 1'b1));
                acc_ids.push_back(1'b1);
                acc_cyc = cyc;
            end
            if (res_valid) begin
                check("rdy0_not_idle", 32'(req0_ready), 32'd0);
                check("rdy1_not_idle", 32'(req1_ready), 32'd0);
                check("busy_done", 32'(busy), 32'd1);
            end
            if (res_valid && !prev_valid)
                check("latency", 32'(cyc - acc_cyc - 1), 32'd4);
            if (res_valid && res_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_res", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("res_diff", 32'(res_diff), 32'(e.diff));
                    check("res_borrow", 32'(res_borrow), 32'(e.borrow));
                    check("res_id", 32'(res_id), 32'(e.id));
                end
            end
            prev_valid = res_valid;
        end
    end

    task automatic send(input logic id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int n = 0;
        @(posedge clk); #1;
        if (id) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b;
        end
        do begin
            @(negedge clk);
            n++;
        end while (!(id ? req1_ready : req0_ready) && n < 100);
        check("accept_timeout", 32'(n < 100), 32'd1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sb.size() != 0 || res_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 32'(n < 200), 32'd1);
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_rdy0"}, 32'(req0_ready), 32'd0);
        check({tag, "_rdy1"}, 32'(req1_ready), 32'd0);
        check({tag, "_valid"}, 32'(res_valid), 32'd0);
        check({tag, "_diff"}, 32'(res_diff), 32'd0);
        check({tag, "_borrow"}, 32'(res_borrow), 32'd0);
        check({tag, "_id"}, 32'(res_id), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [WIDTH-1:0] snap_diff;
        logic             snap_borrow, snap_id;
        int               n;

        rst_n      = 1'b0;
        res_ready  = 1'b1;
        req0_valid = 1'b1; req0_a = 16'h5555; req0_b = 16'h1111;
        req1_valid = 1'b1; req1_a = 16'h0F0F; req1_b = 16'hF0F0;
        repeat (3) @(posedge clk);
        #1 check_reset_outs("rst");

        // Both requesters valid straight out of reset: grants must alternate 0,1,0,1
        rst_n = 1'b1;
        n = 0;
        while (acc_ids.size() < 4 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("alt_timeout", 32'(n < 200), 32'd1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_drain();
        for (int i = 0; i < 4; i++)
            check("alt_id", (i < acc_ids.size()) ? 32'(acc_ids[i]) : 32'd2, 32'(i % 2));

        send(1'b0, 16'h1234, 16'h0234);
        wait_drain();
        send(1'b1, 16'h1000, 16'h0001);
        wait_drain();
        send(1'b0, 16'h0000, 16'h0001);
        wait_drain();
        send(1'b1, 16'hFFFF, 16'hFFFF);
        wait_drain();
        send(1'b0, 16'h0000, 16'hFFFF);
        wait_drain();

        // Back-pressure: result must hold with both requesters knocking
        res_ready = 1'b0;
        send(1'b1, 16'hBEEF, 16'hCAFE);
        n = 0;
        while (!res_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("hold_wait", 32'(res_valid), 32'd1);
        snap_diff = res_diff; snap_borrow = res_borrow; snap_id = res_id;
        @(posedge clk); #1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(res_valid), 32'd1);
            check("hold_diff", 32'(res_diff), 32'(snap_diff));
            check("hold_borrow", 32'(res_borrow), 32'(snap_borrow));
            check("hold_id", 32'(res_id), 32'(snap_id));
        end
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        res_ready  = 1'b1;
        wait_drain();

        // Reset while processing nibble 2 discards the transaction
        send(1'b0, 16'hABCD, 16'h1234);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1 check_reset_outs("midrst");
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("no_res_after_rst", 32'(res_valid), 32'd0);
        send(1'b0, 16'h8000, 16'h7FFF);
        wait_drain();

        for (int i = 0; i < 8; i++) begin
            send(1'($urandom_range(0, 1)), WIDTH'($urandom), WIDTH'($urandom));
            wait_drain();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
